hidden_forward_module: RTL

HIDDEN_FORWARD_MODULE -- requirements
Module: hidden_forward_module

---
 rtl/hidden_forward_module.sv | 128 ++++++++++++
 1 files changed

// File: rtl/hidden_forward_module.sv
// Single-neuron forward pass: four Q6.10 multiply-accumulates onto a biased
// accumulator, then saturation to Q6.10 with ReLU activation and its derivative.
module hidden_forward_module (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [15:0] x1,
    input  logic signed [15:0] x2,
    input  logic signed [15:0] x3,
    input  logic signed [15:0] x4,
    input  logic signed [15:0] w1i1,
    input  logic signed [15:0] w1i2,
    input  logic signed [15:0] w1i3,
    input  logic signed [15:0] w1i4,
    input  logic signed [15:0] bias,
    output logic signed [15:0] z,
    output logic signed [15:0] a,
    output logic signed [15:0] dadz,
    output logic               busy,
    output logic               done,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [15:0] x_r [4];
    logic signed [15:0] w_r [4];
    logic signed [35:0] acc;
    logic [1:0]         idx;

    logic signed [31:0] prod;
    logic signed [35:0] zf;
    logic signed [15:0] z_sat;

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MAC;
            MAC:     if (idx == 2'd3) state_next = ACT;
            ACT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Q6.10 x Q6.10 gives 20 fractional bits, matching the bias pre-shifted by 10.
    always_comb begin
        prod = x_r[idx] * w_r[idx];
        zf   = acc >>> 10;
        if (zf > 36'sd32767) begin
            z_sat = 16'sh7FFF;
        end else if (zf < -36'sd32768) begin
            z_sat = 16'sh8000;
        end else begin
            z_sat = zf[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                x_r[i] <= '0;
                w_r[i] <= '0;
            end
            acc  <= '0;
            idx  <= '0;
            z    <= '0;
            a    <= '0;
            dadz <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r[0] <= x1;
                        x_r[1] <= x2;
                        x_r[2] <= x3;
                        x_r[3] <= x4;
                        w_r[0] <= w1i1;
                        w_r[1] <= w1i2;
                        w_r[2] <= w1i3;
                        w_r[3] <= w1i4;
                        acc    <= $signed({{10{bias[15]}}, bias, 10'b0});
                        idx    <= 2'd0;
                        busy   <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= acc + $signed({{4{prod[31]}}, prod});
                    idx <= idx + 2'd1;
                end
                ACT: begin
                    z    <= z_sat;
                    // Activation and derivative follow the saturated value, not raw acc.
                    if (z_sat > 16'sd0) begin
                        a    <= z_sat;
                        dadz <= 16'sh0400;
                    end else begin
                        a    <= '0;
                        dadz <= '0;
                    end
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
